// File: rtl/jogo_pkg.sv
// Shared game definitions for the player-LED reveal block and its sibling
// button-to-index converter.
//   N_JOGADORES    : number of players / LEDs (valid indices 0..N_JOGADORES-1)
//   W_JOGADOR      : width of a player index
//   estado_leds_t  : reveal sequencer states
//   onehot_jogador : index -> one-hot LED pattern (all zero for invalid index)
package jogo_pkg;

    localparam int unsigned N_JOGADORES = 5;
    localparam int unsigned W_JOGADOR   = 3;

    typedef enum logic [1:0] {
        OCIOSO,
        VARRE,
        PISCA,
        FIXO
    } estado_leds_t;

    function automatic logic [N_JOGADORES-1:0] onehot_jogador(input logic [W_JOGADOR-1:0] idx);
        logic [N_JOGADORES-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < N_JOGADORES; i++) begin
            if (int'(idx) == int'(i)) res[i] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_jogador_leds_if.sv
// Control/status bundle between the game FSM and the player-LED driver.
//   exibir         : 1-cycle strobe, start a reveal of jogador
//   jogador        : player index, meaningful only with exibir
//   apagar         : abort / clear the display
//   leds_jogadores : one-hot LED drive, bit i = player i
//   ocupado        : reveal in progress (scan or blink)
//   pronto         : 1-cycle pulse when the LED settles steady
//   erro           : 1-cycle pulse on exibir with an invalid index
// master = game FSM side, slave = LED driver side.
interface dec_jogador_leds_if import jogo_pkg::*; ();

    logic                   exibir;
    logic [W_JOGADOR-1:0]   jogador;
    logic                   apagar;
    logic [N_JOGADORES-1:0] leds_jogadores;
    logic                   ocupado;
    logic                   pronto;
    logic                   erro;

    modport master (
        output exibir, jogador, apagar,
        input  leds_jogadores, ocupado, pronto, erro
    );

    modport slave (
        input  exibir, jogador, apagar,
        output leds_jogadores, ocupado, pronto, erro
    );

endinterface

// File: rtl/dec_jogador_leds_divisor_tique.sv
// Free-running clock divider with synchronous clear.
//   clock, reset : system clock, asynchronous active-high reset
//   limpa        : hold/clear the count at 0
//   tique        : 1-cycle pulse on the last cycle of every DIV-cycle period
// W is the counter width, shared by all instances of the parent.
module divisor_tique #(
    parameter int unsigned DIV = 2,
    parameter int unsigned W   = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    output logic tique
);

    localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

    logic [W-1:0] contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (limpa || contagem == ULTIMO) begin
            contagem <= '0;
        end else begin
            contagem <= contagem + W'(1);
        end
    end

    assign tique = !limpa && (contagem == ULTIMO);

endmodule

// File: rtl/dec_jogador_leds.sv
// Player-LED reveal sequencer: on a valid exibir it scans a single lit LED
// across all players, blinks the chosen player's LED, then holds it steady.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : exibir/jogador/apagar in; leds_jogadores/ocupado/pronto/erro out
// Player count comes from jogo_pkg so this block and the converter agree.
module dec_jogador_leds import jogo_pkg::*; #(
    parameter int unsigned DIV_VARRE    = 5_000_000,
    parameter int unsigned PASSOS_VARRE = 10,
    parameter int unsigned DIV_PISCA    = 12_500_000,
    parameter int unsigned N_PISCAS     = 3
) (
    input  logic               clock,
    input  logic               reset,
    dec_jogador_leds_if.slave  bus
);

    localparam int unsigned MAX_DIV   = (DIV_VARRE > DIV_PISCA) ? DIV_VARRE : DIV_PISCA;
    localparam int unsigned W_DIV     = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int unsigned N_FASES   = 2 * N_PISCAS;
    localparam int unsigned MAX_PASSO = (PASSOS_VARRE > N_FASES) ? PASSOS_VARRE : N_FASES;
    localparam int unsigned W_PASSO   = $clog2(MAX_PASSO + 1);

    localparam logic [W_PASSO-1:0]     ULTIMO_PASSO = W_PASSO'(PASSOS_VARRE - 1);
    localparam logic [W_PASSO-1:0]     ULTIMA_FASE  = W_PASSO'(N_FASES - 1);
    localparam logic [N_JOGADORES-1:0] LED0         = N_JOGADORES'(1);

    estado_leds_t           estado;
    logic [W_JOGADOR-1:0]   indice;
    logic [W_PASSO-1:0]     passo;
    logic [N_JOGADORES-1:0] leds;
    logic                   ocupado;
    logic                   pronto;
    logic                   erro;

    logic valido;
    logic tique_varre;
    logic tique_pisca;
    logic limpa_varre;
    logic limpa_pisca;

    assign valido = int'(bus.jogador) < int'(N_JOGADORES);

    // Each divider is held at 0 outside its own state, so it always starts
    // from 0 on the edge that enters that state.
    assign limpa_varre = (estado != VARRE) || bus.apagar;
    assign limpa_pisca = (estado != PISCA) || bus.apagar;

    divisor_tique #(.DIV(DIV_VARRE), .W(W_DIV)) u_div_varre (
        .clock (clock),
        .reset (reset),
        .limpa (limpa_varre),
        .tique (tique_varre)
    );

    divisor_tique #(.DIV(DIV_PISCA), .W(W_DIV)) u_div_pisca (
        .clock (clock),
        .reset (reset),
        .limpa (limpa_pisca),
        .tique (tique_pisca)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= OCIOSO;
            indice  <= '0;
            passo   <= '0;
            leds    <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            if (bus.apagar) begin
                // apagar overrides any simultaneous exibir, valid or not.
                estado  <= OCIOSO;
                passo   <= '0;
                leds    <= '0;
                ocupado <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO, FIXO: begin
                        if (bus.exibir) begin
                            if (valido) begin
                                indice  <= bus.jogador;
                                estado  <= VARRE;
                                passo   <= '0;
                                leds    <= LED0;
                                ocupado <= 1'b1;
                            end else begin
                                erro <= 1'b1;
                            end
                        end
                    end
                    VARRE: begin
                        if (tique_varre) begin
                            if (passo == ULTIMO_PASSO) begin
                                estado <= PISCA;
                                passo  <= '0;
                                leds   <= onehot_jogador(indice);
                            end else begin
                                passo <= passo + W_PASSO'(1);
                                leds  <= {leds[N_JOGADORES-2:0], leds[N_JOGADORES-1]};
                            end
                        end
                    end
                    PISCA: begin
                        if (tique_pisca) begin
                            if (passo == ULTIMA_FASE) begin
                                estado  <= FIXO;
                                passo   <= '0;
                                leds    <= onehot_jogador(indice);
                                ocupado <= 1'b0;
                                pronto  <= 1'b1;
                            end else begin
                                // Even phase numbers are lit; passo holds the
                                // phase being left, so odd passo -> lit next.
                                passo <= passo + W_PASSO'(1);
                                leds  <= passo[0] ? onehot_jogador(indice) : '0;
                            end
                        end
                    end
                    default: begin
                        estado <= OCIOSO;
                        leds   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.leds_jogadores = leds;
    assign bus.ocupado        = ocupado;
    assign bus.pronto         = pronto;
    assign bus.erro           = erro;

endmodule

// File: doc/dec_jogador_leds.md
Name: dec_jogador_leds

Overview:
- Drives the per-player indicator LEDs from a 3-bit player index. This is the reverse of the button-to-index conversion.
- When the game FSM chooses a player (vote result, night victim, seer target), it issues a display strobe. The block then plays a suspense scan across all LEDs, blinks the chosen player's LED, and holds it steady until cleared.
- It sits between the game control FSM and the board's player LEDs.

Parameters:
- N_JOGADORES, 5: number of players and LEDs. Valid indices are 0..N_JOGADORES-1.
- DIV_VARRE, 5_000_000: clock cycles per scan step.
- PASSOS_VARRE, 10: number of scan steps before blinking starts (≥1).
- DIV_PISCA, 12_500_000: clock cycles per blink phase (one on-phase or one off-phase).
- N_PISCAS, 3: number of on/off blink pairs (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- exibir  in  1  1-cycle strobe: start a reveal of `jogador`.
- jogador  in  3  player index, sampled only when exibir=1.
- apagar  in  1  level/strobe: abort or clear the display.
- leds_jogadores  out  N_JOGADORES  one-hot LED drive (bit i = player i).
- ocupado  out  1  high while in VARRE or PISCA.
- pronto  out  1  1-cycle pulse on entry to FIXO.
- erro  out  1  1-cycle pulse when exibir is given with an invalid index.

Behaviour:
- Reset is asynchronous, clock and reset as already decided. All outputs are registered.
- Reset values: leds_jogadores=0, ocupado=0, pronto=0, erro=0, state=OCIOSO, all counters=0.
- States: OCIOSO, VARRE, PISCA, FIXO.
- OCIOSO/FIXO with exibir=1 and jogador<N_JOGADORES, at edge k:
  - latch the index;
  - go to VARRE;
  - leds=1 (bit0), ocupado=1.
- OCIOSO/FIXO with exibir=1 and jogador≥N_JOGADORES:
  - erro=1 for one cycle;
  - state, leds and latched index unchanged.
- exibir during VARRE/PISCA is ignored; erro is not raised.
- VARRE:
  - leds is one-hot and walks bit0→bit(N-1), wrapping back to bit0.
  - It advances once every DIV_VARRE cycles.
  - After PASSOS_VARRE steps (PASSOS_VARRE*DIV_VARRE cycles after edge k), go to PISCA.
- PISCA:
  - Starts with leds=onehot(index).
  - Phases alternate onehot/0, each lasting DIV_PISCA cycles, for 2*N_PISCAS phases.
  - Then go to FIXO.
- FIXO:
  - leds=onehot(index), ocupado=0, pronto=1 on the first FIXO cycle only.
  - Holds until apagar or a new valid exibir (which restarts from VARRE step 0).
- apagar=1 in any state:
  - next edge: state=OCIOSO, leds=0, ocupado=0, all counters cleared;
  - pronto is not pulsed.
- apagar and exibir in the same cycle: apagar wins, and exibir is discarded (no erro).
- Asynchronous reset mid-scan or mid-blink returns immediately to the reset values. No reveal resumes after reset.
- Divider counters:
  - count 0..DIV-1, then wrap;
  - their width is clog2 of the maximum DIV;
  - they restart at 0 on every state entry.
- The step/phase counter width is clog2(max(PASSOS_VARRE, 2*N_PISCAS)+1).
- Exactly one LED bit is high, or none. Multiple LEDs are never high at once.

Decomposition:
- Shared package jogo_pkg holds:
  - N_JOGADORES and the index width (3);
  - the state enum for this block;
  - function onehot_jogador(idx) returning the N-bit one-hot value (zero if idx is invalid).
  - The converter block shares N_JOGADORES and the index width.
- One sub-module, divisor_tique:
  - parameter DIV; inputs clock, reset, limpa;
  - output tique, a 1-cycle pulse every DIV cycles.
  - It is instantiated twice, once for scan and once for blink.
  - limpa is driven on state entry.

Test Plan (all scenarios use DIV_VARRE=2, PASSOS_VARRE=7, DIV_PISCA=3, N_PISCAS=2; exibir at edge 0):
- Normal reveal, jogador=3 → leds go through 00001, 00010, 00100, 01000, 10000, 00001, 00010, each held 2 cycles (edges 0–13). Then 01000, 00000, 01000, 00000, each held 3 cycles (edges 14–25). Then 01000 steady from edge 26, with pronto=1 only at edge 26 and ocupado=1 for edges 0–25.
- Invalid index, jogador=6 from OCIOSO → erro=1 for exactly one cycle; leds=00000, ocupado=0, no state change.
- apagar at edge 16 (mid-blink) → edge 17: leds=00000, ocupado=0, OCIOSO; pronto is never asserted.
- exibir jogador=1 at edge 5 during a reveal of jogador=3 → ignored; the final steady leds=01000.
- From FIXO showing jogador 3, exibir jogador=0 together with apagar → OCIOSO, leds=00000. A following exibir jogador=0 alone gives final leds=00001.
- Async reset asserted at edge 9 plus half a cycle → leds=00000 and ocupado=0 immediately without waiting for a clock edge; after release, the block stays idle until the next exibir.
